// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding, mode constants and saturation limit helper
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
    localparam int   MAX_W    = 64;

    function automatic logic [MAX_W-1:0] sat_limit(input logic neg, input int unsigned w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < w - 1; i++) r[i] = ~neg;
        r[w-1] = neg;
        return r;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple add/sub slice built from full_adder cells
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             m,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0]     = cin;
    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i] ^ m),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_serial_unit.sv
// addsub_serial_unit: digit-serial add/sub with valid/ready handshake; ADDSUB_SATURATE_EN enables signed clamping
module addsub_serial_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int SW    = NSTEP > 1 ? $clog2(NSTEP) : 1;

    state_t           state;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] a_r, b_r, shadow, res, fin;
    logic             m_r, carry;
    logic [DIGIT-1:0] s;
    logic             cout, c_msb_in, last, ovf;

    assign in_ready = state == IDLE;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (a_r[step*DIGIT +: DIGIT]),
        .b        (b_r[step*DIGIT +: DIGIT]),
        .m        (m_r),
        .cin      (carry),
        .s        (s),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

`ifdef ADDSUB_SATURATE_EN
    logic [MAX_W-1:0] lim;
    assign lim = sat_limit(a_r[WIDTH-1], WIDTH);
`endif

    // Merge the current slice into the shadow and form the final (optionally clamped) result
    always_comb begin
        res = shadow;
        res[step*DIGIT +: DIGIT] = s;
        ovf  = c_msb_in ^ cout;
        last = step == SW'(NSTEP - 1);
`ifdef ADDSUB_SATURATE_EN
        fin = ovf ? lim[WIDTH-1:0] : res;
`else
        fin = res;
`endif
    end

    // FSM, step counter, operand/shadow registers and registered result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            m_r       <= MODE_ADD;
            shadow    <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= num1;
                    b_r   <= num2;
                    m_r   <= m;
                    carry <= m;
                    step  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    shadow <= res;
                    carry  <= cout;
                    step   <= step + 1'b1;
                    if (last) begin
                        sum       <= fin;
                        c_out     <= cout;
                        overflow  <= ovf;
                        zero      <= fin == '0;
                        negative  <= fin[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
